// File: rtl/uart_tx_if.sv
// uart_tx_if: request/serial-line bundle for uart_tx
//   P_DATA, Data_Valid, PAR_EN, PAR_TYP : requester -> transmitter
//   TX_OUT, Busy                        : transmitter -> requester
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;
    modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, Busy);
    modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock UART transmitter with optional even/odd parity
//   CLK : clock, one serial bit per cycle
//   RST : synchronous active-high reset
//   bus : uart_tx_if slave (request in, registered TX_OUT/Busy out)
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input logic    CLK,
    input logic    RST,
    uart_tx_if.slave bus
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic                  par_typ;
    logic                  last;

    assign last = cnt == CW'(DATA_WIDTH - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bus.TX_OUT <= 1'b1;
            bus.Busy   <= 1'b0;
            cnt        <= '0;
            data       <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.TX_OUT <= 1'b1;
                    bus.Busy   <= 1'b0;
                    if (bus.Data_Valid) begin
                        state      <= START;
                        bus.TX_OUT <= 1'b0;
                        bus.Busy   <= 1'b1;
                        data       <= bus.P_DATA;
                        par_en     <= bus.PAR_EN;
                        par_typ    <= bus.PAR_TYP;
                    end
                end
                START: begin
                    state      <= DATA;
                    cnt        <= '0;
                    bus.TX_OUT <= data[0];
                end
                DATA: begin
                    // counter clears on exit so it never wraps into a repeated bit
                    if (last) begin
                        cnt        <= '0;
                        state      <= par_en ? PARITY : STOP;
                        bus.TX_OUT <= par_en ? (^data ^ par_typ) : 1'b1;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        bus.TX_OUT <= data[cnt + CW'(1)];
                    end
                end
                PARITY: begin
                    state      <= STOP;
                    bus.TX_OUT <= 1'b1;
                end
                STOP: begin
                    state      <= IDLE;
                    bus.TX_OUT <= 1'b1;
                    bus.Busy   <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    bus.TX_OUT <= 1'b1;
                    bus.Busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; expected {Busy,TX_OUT} per cycle is queued at request time
module tb_uart_tx;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] exp_q[$];
    string tag = "reset";

    uart_tx_if #(.DATA_WIDTH(8)) bus ();
    uart_tx #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", t, got, exp);
        end
    endtask

    // Expected {Busy,TX_OUT} for every cycle of one frame plus its trailing idle cycle
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        exp_q.push_back(2'b10);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
        if (pe) exp_q.push_back({1'b1, ^d ^ pt});
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
    endtask

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) check(tag, {bus.Busy, bus.TX_OUT}, exp_q.pop_front());
        else check({tag, "_idle"}, {bus.Busy, bus.TX_OUT}, 2'b01);
    end

    // Called at a negedge; leaves Data_Valid low at the following negedge
    task automatic send(input string t, input logic [7:0] d, input logic pe, input logic pt);
        tag = t;
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.Data_Valid = 1'b1;
        push_frame(d, pe, pt);
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_drain_timeout"}, exp_q.size(), 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.P_DATA = 8'h00;
        bus.Data_Valid = 1'b1;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        // request on the very first edge out of reset
        RST = 1'b0;
        send("a5_nopar", 8'hA5, 1'b0, 1'b0);
        drain();
        send("a5_even", 8'hA5, 1'b1, 1'b0);
        drain();
        send("a5_odd", 8'hA5, 1'b1, 1'b1);
        drain();
        send("01_even", 8'h01, 1'b1, 1'b0);
        drain();
        send("ff_odd", 8'hFF, 1'b1, 1'b1);
        drain();
        send("00_nopar", 8'h00, 1'b0, 1'b1);
        drain();
        // Data_Valid held high; inputs change mid-frame, second frame after one idle cycle
        tag = "held_valid";
        bus.P_DATA = 8'h3C;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b1;
        bus.Data_Valid = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b1);
        push_frame(8'hC3, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        bus.P_DATA = 8'hC3;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (10) @(negedge CLK);
        bus.Data_Valid = 1'b0;
        drain();
        // reset during data bit 3, with a simultaneous request that must be discarded
        send("rst_abort", 8'h5A, 1'b1, 1'b0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        bus.Data_Valid = 1'b1;
        bus.P_DATA = 8'hFF;
        exp_q.delete();
        tag = "rst_abort";
        @(negedge CLK);
        RST = 1'b0;
        bus.Data_Valid = 1'b0;
        repeat (3) @(negedge CLK);
        send("after_rst", 8'h96, 1'b1, 1'b1);
        drain();
        // request pulse while busy is ignored
        send("busy_pulse", 8'hF0, 1'b1, 1'b0);
        repeat (3) @(negedge CLK);
        bus.P_DATA = 8'hFF;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        repeat (6) @(negedge CLK);
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        drain();
        repeat (5) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
